// File: rtl/temporal_encoder.sv
// rtl/temporal_encoder.sv - binary-to-race-logic spike encoder, one value per gamma cycle per channel
module temporal_encoder #(
   parameter int GAMMA_CYCLE_WIDTH = 16,
   parameter int PULSE_WIDTH       = 8,
   parameter int NUM_CH            = 4,
   localparam int VW               = $clog2(GAMMA_CYCLE_WIDTH)
) (
   input  logic                   aclk,
   input  logic                   grst,
   input  logic [NUM_CH*VW-1:0]   in_value,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [NUM_CH-1:0]      spike,
   output logic                   gamma_rst,
   output logic                   underrun
);

   localparam logic [VW-1:0] T_MAX   = VW'(GAMMA_CYCLE_WIDTH - 1);
   localparam logic [VW:0]   T_MAX_X = (VW+1)'(GAMMA_CYCLE_WIDTH - 1);
   localparam logic [VW:0]   PW_X    = (VW+1)'(PULSE_WIDTH);

   // Elaboration-time parameter sanity: G a power of two >= 4, 1 <= PW <= G-2.
   if (GAMMA_CYCLE_WIDTH < 4 || (GAMMA_CYCLE_WIDTH & (GAMMA_CYCLE_WIDTH - 1)) != 0) begin : g_bad_gamma
      $error("GAMMA_CYCLE_WIDTH must be a power of two and at least 4");
   end
   if (PULSE_WIDTH < 1 || PULSE_WIDTH > GAMMA_CYCLE_WIDTH - 2) begin : g_bad_pw
      $error("PULSE_WIDTH must lie in 1..GAMMA_CYCLE_WIDTH-2");
   end

   logic [VW-1:0]          t;
   logic [VW-1:0]          t_next;
   logic                   wrap;
   logic                   accept;
   logic [NUM_CH*VW-1:0]   pend;
   logic                   pend_valid;
   logic                   pend_valid_next;
   logic [NUM_CH*VW-1:0]   active;
   logic [NUM_CH*VW-1:0]   active_next;
   logic                   first_wrap;
   logic [NUM_CH-1:0]      spike_next;

   // Next-state decode: phase advance, buffer hand-off at the wrap, handshake.
   always_comb begin
      wrap            = (t == T_MAX);
      t_next          = t + VW'(1);
      accept          = in_valid & in_ready;
      active_next     = active;
      pend_valid_next = pend_valid;
      if (wrap) begin
         // An empty buffer at the boundary launches an all-infinite gamma cycle.
         active_next     = pend_valid ? pend : '1;
         pend_valid_next = 1'b0;
      end
      // Accept only happens with the buffer empty, so it never races the hand-off.
      if (accept) begin
         pend_valid_next = 1'b1;
      end
   end

   // Spike decode against the phase the outputs will show after this edge,
   // so the registered outputs line up with t without any post-flop logic.
   always_comb begin
      logic [VW:0] v;
      logic [VW:0] lo;
      logic [VW:0] hi;
      logic [VW:0] tn;
      v          = '0;
      lo         = '0;
      hi         = '0;
      tn         = {1'b0, t_next};
      spike_next = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         v  = {1'b0, active_next[i*VW +: VW]};
         lo = v + (VW+1)'(1);
         hi = v + PW_X;
         // Clip at the last phase; pulses never spill into phase 0.
         if (hi > T_MAX_X) begin
            hi = T_MAX_X;
         end
         spike_next[i] = (active_next[i*VW +: VW] != T_MAX) && (tn >= lo) && (tn <= hi);
      end
   end

   // State and output registers; grst returns everything to the power-up state.
   always_ff @(posedge aclk or posedge grst) begin
      if (grst) begin
         t          <= T_MAX;
         pend       <= '0;
         pend_valid <= 1'b0;
         in_ready   <= 1'b1;
         active     <= '1;
         first_wrap <= 1'b1;
         spike      <= '0;
         gamma_rst  <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         t          <= t_next;
         if (accept) begin
            pend <= in_value;
         end
         pend_valid <= pend_valid_next;
         in_ready   <= ~pend_valid_next;
         active     <= active_next;
         if (wrap) begin
            first_wrap <= 1'b0;
         end
         spike      <= spike_next;
         gamma_rst  <= (t_next == '0);
         // The very first boundary after reset has had no chance to receive data.
         underrun   <= wrap & ~pend_valid & ~first_wrap;
      end
   end

endmodule

// File: tb/tb_temporal_encoder.sv
// tb/tb_temporal_encoder.sv - self-checking bench for temporal_encoder
module tb_temporal_encoder;

   localparam int G  = 16;
   localparam int PW = 8;
   localparam int N  = 4;
   localparam int VW = 4;
   localparam int W  = N * VW;

   logic          aclk = 1'b0;
   logic          grst;
   logic [W-1:0]  in_value;
   logic          in_valid;
   logic          in_ready;
   logic [N-1:0]  spike;
   logic          gamma_rst;
   logic          underrun;

   always #5 aclk = ~aclk;

   temporal_encoder #(
      .GAMMA_CYCLE_WIDTH (G),
      .PULSE_WIDTH       (PW),
      .NUM_CH            (N)
   ) dut (
      .aclk      (aclk),
      .grst      (grst),
      .in_value  (in_value),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .spike     (spike),
      .gamma_rst (gamma_rst),
      .underrun  (underrun)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: phase currently shown on the outputs, the value set
   // governing this gamma cycle, and the one-deep pending buffer.
   int  m_phase;
   int  m_act  [N];
   int  m_pend [N];
   bit  m_pend_valid;
   bit  m_first;
   bit  exp_under;

   typedef struct packed {
      logic [W-1:0]        val;
      logic [N-1:0][7:0]   lo;
      logic [N-1:0][7:0]   hi;
   } vec_t;

   vec_t tbl [4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic int val_of(input logic [W-1:0] x, input int i);
      return int'(x[i*VW +: VW]);
   endfunction

   function automatic logic [N-1:0] exp_spike();
      logic [N-1:0] s;
      int v, last;
      s = '0;
      for (int i = 0; i < N; i++) begin
         v    = m_act[i];
         last = (v + PW < G - 1) ? v + PW : G - 1;
         if (v != G - 1 && m_phase >= v + 1 && m_phase <= last) s[i] = 1'b1;
      end
      return s;
   endfunction

   task automatic model_reset();
      m_phase      = G - 1;
      m_pend_valid = 1'b0;
      m_first      = 1'b1;
      exp_under    = 1'b0;
      for (int i = 0; i < N; i++) begin
         m_act[i]  = G - 1;
         m_pend[i] = 0;
      end
   endtask

   task automatic model_edge(input bit v, input logic [W-1:0] val);
      bit ready_before;
      bit at_wrap;
      if (grst) begin
         model_reset();
         return;
      end
      ready_before = !m_pend_valid;
      at_wrap      = (m_phase == G - 1);
      m_phase      = (m_phase + 1) % G;
      exp_under    = 1'b0;
      if (at_wrap) begin
         if (m_pend_valid) begin
            m_act        = m_pend;
            m_pend_valid = 1'b0;
         end else begin
            for (int i = 0; i < N; i++) m_act[i] = G - 1;
            exp_under = !m_first;
         end
         m_first = 1'b0;
      end
      if (v && ready_before) begin
         for (int i = 0; i < N; i++) m_pend[i] = val_of(val, i);
         m_pend_valid = 1'b1;
      end
   endtask

   task automatic check_outputs();
      chk("spike",     32'(spike),     32'(exp_spike()));
      chk("gamma_rst", 32'(gamma_rst), 32'(m_phase == 0));
      chk("underrun",  32'(underrun),  32'(exp_under));
      chk("in_ready",  32'(in_ready),  32'(!m_pend_valid));
   endtask

   // One clock: check what is shown now, drive the next inputs, advance the model.
   task automatic cyc(input bit v, input logic [W-1:0] val);
      check_outputs();
      in_valid = v;
      in_value = val;
      @(posedge aclk);
      model_edge(v, val);
      @(negedge aclk);
   endtask

   task automatic idle_until(input int k);
      for (int n = 0; n < 2 * G; n++) begin
         if (m_phase == k) return;
         cyc(1'b0, '0);
      end
      chk("idle_until_timeout", 32'(m_phase), 32'(k));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N-1:0]  or_acc;
      logic [W-1:0]  rv;
      logic [W-1:0]  acc_q [$];
      logic [W-1:0]  rec_q [$];
      int            dec [N];
      int            lo, hi;

      tbl[0] = '{val: 16'h6730, lo: {8'd7,  8'd8,  8'd4,  8'd1},  hi: {8'd14, 8'd15, 8'd11, 8'd8}};
      tbl[1] = '{val: 16'hDFEA, lo: {8'd14, 8'd99, 8'd15, 8'd11}, hi: {8'd15, 8'd0,  8'd15, 8'd15}};
      tbl[2] = '{val: 16'hFFFF, lo: {8'd99, 8'd99, 8'd99, 8'd99}, hi: {8'd0,  8'd0,  8'd0,  8'd0}};
      tbl[3] = '{val: 16'h4512, lo: {8'd5,  8'd6,  8'd2,  8'd3},  hi: {8'd12, 8'd13, 8'd9,  8'd10}};

      grst     = 1'b1;
      in_valid = 1'b0;
      in_value = '0;
      model_reset();
      @(negedge aclk);

      // Reset held for 5 cycles.
      for (int n = 0; n < 5; n++) cyc(1'b0, '0);
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      grst = 1'b0;
      cyc(1'b0, '0);
      chk("first_gamma_rst", 32'(gamma_rst), 32'd1);
      chk("first_no_underrun", 32'(underrun), 32'd0);
      cyc(1'b0, '0);
      chk("gamma_rst_one_cycle", 32'(gamma_rst), 32'd0);

      // Table-driven encode vectors, each accepted at phase 3 and observed next gamma cycle.
      for (int j = 0; j < 4; j++) begin
         idle_until(3);
         cyc(1'b1, tbl[j].val);
         idle_until(0);
         for (int k = 0; k < G; k++) begin
            for (int i = 0; i < N; i++) begin
               lo = int'(tbl[j].lo[i]);
               hi = int'(tbl[j].hi[i]);
               chk($sformatf("tbl%0d_ch%0d_t%0d", j, i, k), 32'(spike[i]), 32'(k >= lo && k <= hi));
            end
            cyc(1'b0, '0);
         end
      end

      // Gamma cycle with nothing pending.
      chk("underrun_pulse", 32'(underrun), 32'd1);
      cyc(1'b0, '0);
      chk("underrun_one_cycle", 32'(underrun), 32'd0);

      // Accept exactly on the wrap edge: infinite gamma cycle first, value one cycle later.
      idle_until(G - 1);
      cyc(1'b1, 16'h0000);
      chk("wrap_accept_ready_low", 32'(in_ready), 32'd0);
      chk("wrap_accept_underrun", 32'(underrun), 32'd1);
      or_acc = '0;
      for (int k = 0; k < G; k++) begin
         or_acc |= spike;
         cyc(1'b0, '0);
      end
      chk("wrap_accept_gap_silent", 32'(or_acc), 32'd0);
      cyc(1'b0, '0);
      chk("wrap_accept_late_spike", 32'(spike), 32'hF);

      // Backpressure: in_valid held high with fresh data every cycle.
      idle_until(0);
      for (int k = 0; k < 9 * G; k++) begin
         rv = W'($urandom);
         if (in_ready) acc_q.push_back(rv);
         if (m_phase == 0) begin
            for (int i = 0; i < N; i++) dec[i] = G - 1;
         end else begin
            for (int i = 0; i < N; i++)
               if (spike[i] && dec[i] == G - 1) dec[i] = m_phase - 1;
         end
         if (m_phase == G - 1) begin
            for (int i = 0; i < N; i++) rv[i*VW +: VW] = VW'(dec[i]);
            rec_q.push_back(rv);
            rv = W'($urandom);
         end
         cyc(1'b1, rv);
      end
      in_valid = 1'b0;
      chk("accepts_per_gamma", 32'(acc_q.size()), 32'd9);
      for (int j = 0; j < 8; j++) begin
         if (j + 1 < rec_q.size() && j < acc_q.size())
            chk($sformatf("stream_value_%0d", j), 32'(rec_q[j+1]), 32'(acc_q[j]));
         else
            chk($sformatf("stream_value_%0d_missing", j), 32'd0, 32'd1);
      end

      // Mid-operation reset while ch0 is spiking and the buffer holds a value.
      idle_until(2);
      cyc(1'b1, 16'hFFF0);
      idle_until(0);
      idle_until(3);
      cyc(1'b1, 16'h0000);
      idle_until(5);
      chk("pre_reset_spike0", 32'(spike[0]), 32'd1);
      #2;
      grst = 1'b1;
      #1;
      model_reset();
      chk("async_spike", 32'(spike), 32'd0);
      chk("async_gamma_rst", 32'(gamma_rst), 32'd0);
      chk("async_underrun", 32'(underrun), 32'd0);
      chk("async_in_ready", 32'(in_ready), 32'd1);
      @(negedge aclk);
      for (int n = 0; n < 3; n++) cyc(1'b0, '0);
      grst = 1'b0;
      cyc(1'b0, '0);
      chk("rst2_gamma_rst", 32'(gamma_rst), 32'd1);
      chk("rst2_no_underrun", 32'(underrun), 32'd0);
      or_acc = '0;
      for (int k = 0; k < 2 * G; k++) begin
         or_acc |= spike;
         cyc(1'b0, '0);
      end
      chk("no_stale_pending", 32'(or_acc), 32'd0);

      // Randomized traffic against the model.
      for (int k = 0; k < 600; k++) begin
         cyc(($urandom % 3) == 0, W'($urandom));
      end
      check_outputs();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
